// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds the widths and the grant encoding.
package rf_wr_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_DIV  = 2'd2
  } gnt_e;
endpackage

// File: rtl/rf_pend_scoreboard.sv
// Bitmap of registers waiting on a divider write.
// Also does the decode hazard lookup.
module rf_pend_scoreboard
  import rf_wr_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic             hazard
);

  logic [31:0] pend;
  logic [31:0] pend_nxt;

  // Clear first so a same-register set wins; x0 never pends.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_rd] = 1'b0;
    if (set_en) pend_nxt[set_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Pending bitmap register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign hazard = pend[rs1] | pend[rs2] | pend[rd];

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port between the
// pipeline writeback and the buffered divider result.
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_valid,
  input  logic             pipe_we,
  input  logic [REG_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]  pipe_wdata,
  output logic             pipe_allow_in,
  input  logic             div_valid,
  input  logic [REG_W-1:0] div_rd,
  input  logic [XLEN-1:0]  div_wdata,
  output logic             div_ready,
  input  logic             div_issue,
  input  logic [REG_W-1:0] div_issue_rd,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic [REG_W-1:0] dec_rd,
  output logic             dec_hazard,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_wdata,
  output logic             wb_we
);

  logic             buf_full;
  logic [REG_W-1:0] buf_rd;
  logic [XLEN-1:0]  buf_wdata;
  logic [3:0]       starve_cnt;
  logic             pipe_wr;
  logic             force_div;
  logic             div_xfer;
  logic             drain;
  gnt_e             gnt;

  assign pipe_wr   = pipe_valid && pipe_we && (pipe_rd != '0);
  assign force_div = buf_full && (starve_cnt == 4'(STARVE_MAX));

  // Both handshakes read low while reset is held.
  assign pipe_allow_in = reset && !force_div;
  assign div_ready     = reset && !buf_full;
  assign div_xfer      = div_valid && div_ready;

  // Fixed priority: starved divider, pipeline, divider.
  always_comb begin
    gnt = GNT_NONE;
    if (force_div)                     gnt = GNT_DIV;
    else if (pipe_wr && pipe_allow_in) gnt = GNT_PIPE;
    else if (buf_full)                 gnt = GNT_DIV;
  end

  assign drain = (gnt == GNT_DIV);

  // One-entry result buffer; load only when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full  <= 1'b0;
      buf_rd    <= '0;
      buf_wdata <= '0;
    end else if (drain) begin
      buf_full  <= 1'b0;
    end else if (div_xfer) begin
      buf_full  <= 1'b1;
      buf_rd    <= div_rd;
      buf_wdata <= div_wdata;
    end
  end

  // Cycles the buffered result has lost the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (!buf_full || drain)
      starve_cnt <= '0;
    else if (starve_cnt != 4'(STARVE_MAX))
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Registered write port; x0 drains never write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_wdata <= '0;
    end else begin
      unique case (gnt)
        GNT_PIPE: begin
          wb_we    <= 1'b1;
          wb_rd    <= pipe_rd;
          wb_wdata <= pipe_wdata;
        end
        GNT_DIV: begin
          wb_we    <= (buf_rd != '0);
          wb_rd    <= buf_rd;
          wb_wdata <= buf_wdata;
        end
        default: wb_we <= 1'b0;
      endcase
    end
  end

  rf_pend_scoreboard u_sb (
    .clk    (clk),
    .rst_n  (reset),
    .set_en (div_issue && (div_issue_rd != '0)),
    .set_rd (div_issue_rd),
    .clr_en (drain),
    .clr_rd (buf_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .rd     (dec_rd),
    .hazard (dec_hazard)
  );

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter.
// Expected values are hand-computed per vector.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        pipe_allow_in;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_wdata;
  logic        div_ready;
  logic        div_issue;
  logic [4:0]  div_issue_rd;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_hazard;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        wb_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.STARVE_MAX(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_valid    (pipe_valid),
    .pipe_we       (pipe_we),
    .pipe_rd       (pipe_rd),
    .pipe_wdata    (pipe_wdata),
    .pipe_allow_in (pipe_allow_in),
    .div_valid     (div_valid),
    .div_rd        (div_rd),
    .div_wdata     (div_wdata),
    .div_ready     (div_ready),
    .div_issue     (div_issue),
    .div_issue_rd  (div_issue_rd),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rd        (dec_rd),
    .dec_hazard    (dec_hazard),
    .wb_rd         (wb_rd),
    .wb_wdata      (wb_wdata),
    .wb_we         (wb_we)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic we,
                        input logic [4:0] rd,
                        input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, wb_we}, {31'd0, we});
    chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    chk({tag, "_data"}, wb_wdata, d);
  endtask

  initial begin
    reset = 1'b0;
    pipe_valid = 0; pipe_we = 0;
    pipe_rd = 0; pipe_wdata = 0;
    div_valid = 0; div_rd = 0; div_wdata = 0;
    div_issue = 0; div_issue_rd = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;

    step(); step();
    chk("rst_we", {31'd0, wb_we}, 0);
    chk("rst_allow", {31'd0, pipe_allow_in}, 0);
    chk("rst_ready", {31'd0, div_ready}, 0);
    chk("rst_haz", {31'd0, dec_hazard}, 0);
    reset = 1'b1;
    #1;
    chk("rel_allow", {31'd0, pipe_allow_in}, 1);
    chk("rel_ready", {31'd0, div_ready}, 1);

    // pipeline only
    pipe_valid = 1; pipe_we = 1;
    pipe_rd = 5'd2; pipe_wdata = 32'd2;
    step();
    chk_wb("pipe", 1, 5'd2, 32'd2);
    chk("pipe_allow", {31'd0, pipe_allow_in}, 1);
    pipe_valid = 0;
    step();
    chk("pipe_idle", {31'd0, wb_we}, 0);

    // divider into idle slot
    div_issue = 1; div_issue_rd = 5'd5;
    step();
    div_issue = 0; dec_rs1 = 5'd5;
    #1;
    chk("div_haz_set", {31'd0, dec_hazard}, 1);
    div_valid = 1; div_rd = 5'd5; div_wdata = 32'h7;
    step();
    div_valid = 0;
    #1;
    chk("div_buf_ready", {31'd0, div_ready}, 0);
    chk("div_buf_we", {31'd0, wb_we}, 0);
    chk("div_buf_haz", {31'd0, dec_hazard}, 1);
    step();
    chk_wb("div_wr", 1, 5'd5, 32'h7);
    chk("div_wr_haz", {31'd0, dec_hazard}, 0);
    chk("div_wr_ready", {31'd0, div_ready}, 1);
    dec_rs1 = 0;

    // starvation
    div_valid = 1; div_rd = 5'd6; div_wdata = 32'h66;
    step();
    div_valid = 0;
    pipe_valid = 1; pipe_we = 1; pipe_rd = 5'd3;
    for (int i = 0; i < 4; i++) begin
      pipe_wdata = 32'h100 + i;
      #1;
      chk("stv_allow", {31'd0, pipe_allow_in}, 1);
      step();
      chk_wb("stv_pipe", 1, 5'd3, 32'h100 + i);
    end
    chk("stv_hold", {31'd0, pipe_allow_in}, 0);
    step();
    chk_wb("stv_div", 1, 5'd6, 32'h66);
    chk("stv_resume", {31'd0, pipe_allow_in}, 1);
    pipe_valid = 0;
    step();
    chk("stv_idle", {31'd0, wb_we}, 0);

    // non-writing pipe slot drains buffer
    div_valid = 1; div_rd = 5'd8; div_wdata = 32'h88;
    step();
    div_valid = 0;
    pipe_valid = 1; pipe_we = 1;
    pipe_rd = 5'd4; pipe_wdata = 32'h44;
    step();
    chk_wb("nw_pipe", 1, 5'd4, 32'h44);
    chk("nw_cnt1", {28'd0, dut.starve_cnt}, 1);
    pipe_we = 0;
    step();
    chk_wb("nw_drain", 1, 5'd8, 32'h88);
    chk("nw_cnt0", {28'd0, dut.starve_cnt}, 0);
    chk("nw_ready", {31'd0, div_ready}, 1);
    pipe_valid = 0;

    // same-cycle set/clear on x7
    div_issue = 1; div_issue_rd = 5'd7;
    step();
    div_issue = 0;
    div_valid = 1; div_rd = 5'd7; div_wdata = 32'h77;
    step();
    div_valid = 0;
    div_issue = 1; div_issue_rd = 5'd7;
    step();
    div_issue = 0; dec_rs2 = 5'd7;
    chk_wb("sc_drain", 1, 5'd7, 32'h77);
    #1;
    chk("sc_haz", {31'd0, dec_hazard}, 1);
    div_valid = 1; div_rd = 5'd7; div_wdata = 32'h70;
    step();
    div_valid = 0;
    step();
    chk_wb("sc_wr2", 1, 5'd7, 32'h70);
    chk("sc_haz_clr", {31'd0, dec_hazard}, 0);
    dec_rs2 = 0;

    // x0 divider result and x0 pipe slot
    div_valid = 1; div_rd = 5'd0; div_wdata = 32'h99;
    step();
    div_valid = 0;
    step();
    chk("x0_div_we", {31'd0, wb_we}, 0);
    chk("x0_div_ready", {31'd0, div_ready}, 1);
    pipe_valid = 1; pipe_we = 1;
    pipe_rd = 5'd0; pipe_wdata = 32'h5;
    #1;
    chk("x0_pipe_allow", {31'd0, pipe_allow_in}, 1);
    step();
    chk("x0_pipe_we", {31'd0, wb_we}, 0);

    // reset mid-operation
    pipe_valid = 0;
    div_issue = 1; div_issue_rd = 5'd9;
    step();
    div_issue = 0;
    div_valid = 1; div_rd = 5'd9; div_wdata = 32'h99;
    step();
    div_valid = 0;
    pipe_valid = 1; pipe_we = 1;
    pipe_rd = 5'd1; pipe_wdata = 32'h1;
    dec_rs1 = 5'd9;
    step();
    chk_wb("mid_pipe", 1, 5'd1, 32'h1);
    chk("mid_haz", {31'd0, dec_hazard}, 1);
    reset = 1'b0;
    #1;
    chk("ar_ready", {31'd0, div_ready}, 0);
    chk("ar_we", {31'd0, wb_we}, 0);
    chk("ar_haz", {31'd0, dec_hazard}, 0);
    chk("ar_allow", {31'd0, pipe_allow_in}, 0);
    pipe_valid = 0;
    step();
    reset = 1'b1;
    #1;
    chk("ar_rel_ready", {31'd0, div_ready}, 1);
    step();
    chk("ar_stale1", {31'd0, wb_we}, 0);
    step();
    chk("ar_stale2", {31'd0, wb_we}, 0);
    chk("ar_rel_haz", {31'd0, dec_hazard}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
